// File: rtl/sprite_motion_engine_if.sv
// Load channel for sprite_motion_engine: valid/ready handshake that
// overwrites one sprite's position while the engine is idle.
interface sprite_motion_engine_if #(
   parameter int COORD_W = 10,
   parameter int ID_W    = 2
);
   logic               load_valid;
   logic               load_ready;
   logic [ID_W-1:0]    load_id;
   logic [COORD_W-1:0] load_x;
   logic [COORD_W-1:0] load_y;

   modport master (output load_valid, load_id, load_x, load_y, input load_ready);
   modport slave  (input load_valid, load_id, load_x, load_y, output load_ready);
endinterface

// File: rtl/sprite_motion_engine.sv
// Per-frame sprite position engine: one sprite per clock, bounce or player
// motion, edge saturation, position load and frame handshaking.
module sprite_motion_engine #(
   parameter int NUM_SPRITES  = 4,
   parameter int COORD_W      = 10,
   parameter int SCREEN_W     = 640,
   parameter int SCREEN_H     = 480,
   parameter int BOUNCE_SPEED = 1,
   parameter int PLAYER_SPEED = 5
) (
   input  logic                           CLOCK,
   input  logic                           RESET_N,
   input  logic                           frame_tick,
   input  logic [NUM_SPRITES-1:0]         mode,
   input  logic [4*NUM_SPRITES-1:0]       keys,
   input  logic [COORD_W*NUM_SPRITES-1:0] sprite_w,
   input  logic [COORD_W*NUM_SPRITES-1:0] sprite_h,
   sprite_motion_engine_if.slave          ld,
   output logic [COORD_W*NUM_SPRITES-1:0] pos_x,
   output logic [COORD_W*NUM_SPRITES-1:0] pos_y,
   output logic                           busy,
   output logic                           frame_done,
   output logic                           tick_overrun
);
   localparam int ID_W = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1;
   localparam int CW1  = COORD_W + 1;

   typedef logic [CW1-1:0] wide_t;
   typedef struct packed {
      wide_t p;
      logic  neg;
   } axis_t;
   typedef enum logic [1:0] {IDLE, UPDATE, DONE} state_t;

   localparam wide_t SCR_W = CW1'(SCREEN_W);
   localparam wide_t SCR_H = CW1'(SCREEN_H);
   localparam wide_t B_SPD = CW1'(BOUNCE_SPEED);
   localparam wide_t P_SPD = CW1'(PLAYER_SPEED);

   state_t             state, next_state;
   logic [ID_W-1:0]    idx, next_idx;
   logic               load_fire;

   logic [COORD_W-1:0] px    [NUM_SPRITES];
   logic [COORD_W-1:0] py    [NUM_SPRITES];
   logic               neg_x [NUM_SPRITES];
   logic               neg_y [NUM_SPRITES];
   wide_t              max_x [NUM_SPRITES];
   wide_t              max_y [NUM_SPRITES];

   logic               cur_mode;
   logic [3:0]         cur_keys;
   axis_t              bx, by;
   wide_t              plx, ply;
   wide_t              ld_max_x, ld_max_y;
   logic [COORD_W-1:0] ld_x, ld_y;

   function automatic wide_t limit(input wide_t screen, input logic [COORD_W-1:0] size);
      return ({1'b0, size} >= screen) ? '0 : screen - {1'b0, size};
   endfunction

   // Clamp and reversal share one update so a sprite never idles at an edge.
   function automatic axis_t bounce_axis(input wide_t p, input wide_t lim, input logic neg);
      axis_t r;
      r.p   = p;
      r.neg = neg;
      if (p > lim) begin
         r.p   = lim;
         r.neg = 1'b1;
      end else if (!neg) begin
         if (p + B_SPD >= lim) begin
            r.p   = lim;
            r.neg = 1'b1;
         end else begin
            r.p = p + B_SPD;
         end
      end else if (p <= B_SPD) begin
         r.p   = '0;
         r.neg = 1'b0;
      end else begin
         r.p = p - B_SPD;
      end
      return r;
   endfunction

   function automatic wide_t player_axis(input wide_t p, input wide_t lim,
                                         input logic dec, input logic inc);
      wide_t q;
      q = p;
      if (dec && !inc)      q = (p >= P_SPD) ? p - P_SPD : '0;
      else if (inc && !dec) q = p + P_SPD;
      return (q > lim) ? lim : q;
   endfunction

   always_comb begin
      for (int i = 0; i < NUM_SPRITES; i++) begin
         max_x[i] = limit(SCR_W, sprite_w[i*COORD_W +: COORD_W]);
         max_y[i] = limit(SCR_H, sprite_h[i*COORD_W +: COORD_W]);
      end
   end

   // Datapath for the sprite currently indexed, plus the clamped load value.
   always_comb begin
      cur_mode = mode[idx];
      cur_keys = keys[{idx, 2'b00} +: 4];
      bx  = bounce_axis({1'b0, px[idx]}, max_x[idx], neg_x[idx]);
      by  = bounce_axis({1'b0, py[idx]}, max_y[idx], neg_y[idx]);
      plx = player_axis({1'b0, px[idx]}, max_x[idx], cur_keys[1], cur_keys[3]);
      ply = player_axis({1'b0, py[idx]}, max_y[idx], cur_keys[0], cur_keys[2]);
      ld_max_x = '0;
      ld_max_y = '0;
      for (int i = 0; i < NUM_SPRITES; i++) begin
         if (ID_W'(i) == ld.load_id) begin
            ld_max_x = max_x[i];
            ld_max_y = max_y[i];
         end
      end
      ld_x = ({1'b0, ld.load_x} > ld_max_x) ? ld_max_x[COORD_W-1:0] : ld.load_x;
      ld_y = ({1'b0, ld.load_y} > ld_max_y) ? ld_max_y[COORD_W-1:0] : ld.load_y;
   end

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      next_state    = state;
      next_idx      = idx;
      load_fire     = 1'b0;
      ld.load_ready = (state == IDLE);
      busy          = (state == UPDATE);
      frame_done    = (state == DONE);
      unique case (state)
         IDLE: begin
            if (frame_tick) begin
               next_state = UPDATE;
               next_idx   = '0;
            end else if (ld.load_valid) begin
               load_fire = 1'b1;
            end
         end
         UPDATE: begin
            if (idx == ID_W'(NUM_SPRITES - 1)) begin
               next_state = DONE;
               next_idx   = '0;
            end else begin
               next_idx = idx + ID_W'(1);
            end
         end
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(negedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         state        <= IDLE;
         idx          <= '0;
         tick_overrun <= 1'b0;
      end else begin
         state <= next_state;
         idx   <= next_idx;
         if (frame_tick && state != IDLE) tick_overrun <= 1'b1;
      end
   end

   // NOTE: the position/direction arrays are reset explicitly because pos_x/pos_y must read 0 out of reset.
   always_ff @(negedge CLOCK or negedge RESET_N) begin
      if (!RESET_N) begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            px[i]    <= '0;
            py[i]    <= '0;
            neg_x[i] <= 1'b0;
            neg_y[i] <= 1'b0;
         end
      end else if (state == UPDATE) begin
         if (cur_mode) begin
            px[idx] <= plx[COORD_W-1:0];
            py[idx] <= ply[COORD_W-1:0];
         end else begin
            px[idx]    <= bx.p[COORD_W-1:0];
            py[idx]    <= by.p[COORD_W-1:0];
            neg_x[idx] <= bx.neg;
            neg_y[idx] <= by.neg;
         end
      end else if (load_fire) begin
         for (int i = 0; i < NUM_SPRITES; i++) begin
            if (ID_W'(i) == ld.load_id) begin
               px[i] <= ld_x;
               py[i] <= ld_y;
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_out
      assign pos_x[g*COORD_W +: COORD_W] = px[g];
      assign pos_y[g*COORD_W +: COORD_W] = py[g];
   end
endmodule

// File: tb/tb_sprite_motion_engine.sv
// Scoreboarded bench for sprite_motion_engine: a per-frame reference model
// pushes expected positions, a monitor compares them on every frame_done.
module tb_sprite_motion_engine;
   localparam int NS = 4, CW = 10, IW = 2;
   localparam int SW = 640, SH = 480, BS = 1, PS = 5;

   logic                CLOCK, RESET_N, frame_tick;
   logic [NS-1:0]       mode;
   logic [4*NS-1:0]     keys;
   logic [CW*NS-1:0]    sprite_w, sprite_h, pos_x, pos_y;
   logic                busy, frame_done, tick_overrun;

   sprite_motion_engine_if #(.COORD_W(CW), .ID_W(IW)) ld();

   sprite_motion_engine #(
      .NUM_SPRITES(NS), .COORD_W(CW), .SCREEN_W(SW), .SCREEN_H(SH),
      .BOUNCE_SPEED(BS), .PLAYER_SPEED(PS)
   ) dut (
      .CLOCK(CLOCK), .RESET_N(RESET_N), .frame_tick(frame_tick),
      .mode(mode), .keys(keys), .sprite_w(sprite_w), .sprite_h(sprite_h),
      .ld(ld), .pos_x(pos_x), .pos_y(pos_y),
      .busy(busy), .frame_done(frame_done), .tick_overrun(tick_overrun)
   );

   typedef struct packed {
      logic [CW*NS-1:0] x;
      logic [CW*NS-1:0] y;
   } snap_t;

   snap_t exp_q[$];
   int n_checks = 0, n_fail = 0, frames_exp = 0, done_seen = 0;
   // Model state: position and signed velocity per axis.
   int m_x[NS], m_y[NS], m_vx[NS], m_vy[NS];

   initial CLOCK = 1'b0;
   always #5 CLOCK = ~CLOCK;

   initial begin
      #2000000;
      $display("FAIL global_timeout: simulation did not finish, required finish before 2 ms");
      $fatal(1, "global timeout");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   function automatic int lim(input int scr, input int sz);
      return (sz >= scr) ? 0 : scr - sz;
   endfunction

   function automatic int w_of(input int i); return int'(sprite_w[i*CW +: CW]); endfunction
   function automatic int h_of(input int i); return int'(sprite_h[i*CW +: CW]); endfunction
   function automatic int dut_x(input int i); return int'(pos_x[i*CW +: CW]); endfunction
   function automatic int dut_y(input int i); return int'(pos_y[i*CW +: CW]); endfunction

   task automatic model_reset();
      for (int i = 0; i < NS; i++) begin
         m_x[i] = 0; m_y[i] = 0; m_vx[i] = BS; m_vy[i] = BS;
      end
   endtask

   task automatic model_bounce(inout int p, inout int v, input int mx);
      int np;
      if (p > mx) begin
         p = mx; v = -BS;
      end else begin
         np = p + v;
         if (v > 0 && np >= mx) begin
            p = mx; v = -BS;
         end else if (v < 0 && np <= 0) begin
            p = 0; v = BS;
         end else begin
            p = np;
         end
      end
   endtask

   function automatic int model_player(input int p, input bit dec, input bit inc, input int mx);
      int q;
      q = p + PS * (int'(inc) - int'(dec));
      if (q < 0) q = 0;
      if (q > mx) q = mx;
      return q;
   endfunction

   task automatic model_frame();
      snap_t s;
      for (int i = 0; i < NS; i++) begin
         if (mode[i]) begin
            m_x[i] = model_player(m_x[i], keys[4*i+1], keys[4*i+3], lim(SW, w_of(i)));
            m_y[i] = model_player(m_y[i], keys[4*i+0], keys[4*i+2], lim(SH, h_of(i)));
         end else begin
            model_bounce(m_x[i], m_vx[i], lim(SW, w_of(i)));
            model_bounce(m_y[i], m_vy[i], lim(SH, h_of(i)));
         end
         s.x[i*CW +: CW] = CW'(m_x[i]);
         s.y[i*CW +: CW] = CW'(m_y[i]);
      end
      exp_q.push_back(s);
      frames_exp++;
   endtask

   task automatic model_load(input int id, input int x, input int y);
      m_x[id] = (x > lim(SW, w_of(id))) ? lim(SW, w_of(id)) : x;
      m_y[id] = (y > lim(SH, h_of(id))) ? lim(SH, h_of(id)) : y;
   endtask

   task automatic wait_cyc();
      @(posedge CLOCK);
      #1;
   endtask

   task automatic set_size(input int i, input int w, input int h);
      sprite_w[i*CW +: CW] = CW'(w);
      sprite_h[i*CW +: CW] = CW'(h);
   endtask

   task automatic do_load(input int id, input int x, input int y);
      ld.load_valid = 1'b1;
      ld.load_id    = IW'(id);
      ld.load_x     = CW'(x);
      ld.load_y     = CW'(y);
      @(posedge CLOCK);
      check("load_ready_idle", ld.load_ready, 1);
      model_load(id, x, y);
      #1 ld.load_valid = 1'b0;
   endtask

   // One frame: optional overrun tick at cycle ovr_at, load attempts while busy
   // or together with the tick (neither may be accepted).
   task automatic run_frame(input int ovr_at, input bit busy_load, input bit tick_load);
      int  n;
      bit  seen;
      model_frame();
      frame_tick = 1'b1;
      if (tick_load) begin
         ld.load_valid = 1'b1; ld.load_id = '0; ld.load_x = CW'(7); ld.load_y = CW'(9);
      end
      seen = 1'b0;
      n    = 0;
      while (!seen && n < NS + 20) begin
         @(posedge CLOCK);
         n++;
         seen = (frame_done === 1'b1);
         if (n == 1) check("busy_in_update", busy, 1);
         if (busy_load && n == 2) check("load_ready_busy", ld.load_ready, 0);
         #1;
         frame_tick    = (n == ovr_at);
         ld.load_valid = busy_load && (n < NS);
      end
      frame_tick    = 1'b0;
      ld.load_valid = 1'b0;
      check("frame_done_seen", seen, 1);
      check("frame_latency", n, NS + 1);
      wait_cyc();
      check("frame_done_width", frame_done, 0);
   endtask

   always @(posedge CLOCK) begin
      if (RESET_N === 1'b1 && frame_done === 1'b1) begin
         snap_t e;
         done_seen++;
         check("sb_nonempty", exp_q.size() > 0, 1);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int i = 0; i < NS; i++) begin
               check($sformatf("frame%0d_x%0d", done_seen, i), pos_x[i*CW +: CW], e.x[i*CW +: CW]);
               check($sformatf("frame%0d_y%0d", done_seen, i), pos_y[i*CW +: CW], e.y[i*CW +: CW]);
            end
         end
      end
   end

   initial begin
      RESET_N = 1'b1; frame_tick = 1'b0; mode = '0; keys = '0;
      ld.load_valid = 1'b0; ld.load_id = '0; ld.load_x = '0; ld.load_y = '0;
      for (int i = 0; i < NS; i++) set_size(i, 8, 8);
      model_reset();
      #3 RESET_N = 1'b0;
      #1;
      check("reset_pos_x", pos_x, 0);
      check("reset_pos_y", pos_y, 0);
      check("reset_busy", busy, 0);
      check("reset_frame_done", frame_done, 0);
      check("reset_overrun", tick_overrun, 0);
      repeat (2) wait_cyc();
      RESET_N = 1'b1;
      wait_cyc();
      check("idle_load_ready", ld.load_ready, 1);

      // Bounce from origin: every sprite to (1,1).
      run_frame(-1, 0, 0);
      for (int i = 0; i < NS; i++) begin
         check($sformatf("t1_x%0d", i), dut_x(i), 1);
         check($sformatf("t1_y%0d", i), dut_y(i), 1);
      end

      // Bounce at the far corner: clamp and reverse, then step back.
      set_size(1, 10, 10);
      do_load(1, 630, 470);
      check("t2_load_x", dut_x(1), 630);
      run_frame(-1, 0, 0);
      check("t2_edge_x", dut_x(1), 630);
      check("t2_edge_y", dut_y(1), 470);
      run_frame(-1, 0, 0);
      check("t2_back_x", dut_x(1), 629);
      check("t2_back_y", dut_y(1), 469);

      // Load clamps to the sprite's max.
      do_load(0, 1000, 1000);
      check("load_clamp_x", dut_x(0), 632);
      check("load_clamp_y", dut_y(0), 472);

      // Player saturation at 0 and opposing keys.
      mode[2] = 1'b1;
      do_load(2, 2, 2);
      keys[8 +: 4] = 4'b0011;
      run_frame(-1, 0, 0);
      check("t3_upleft_x", dut_x(2), 0);
      check("t3_upleft_y", dut_y(2), 0);
      do_load(2, 20, 20);
      keys[8 +: 4] = 4'b0101;
      run_frame(-1, 0, 0);
      check("t3_updown_y", dut_y(2), 20);

      // Player saturation at the right edge held for several frames.
      mode[3] = 1'b1;
      set_size(3, 155, 8);
      do_load(3, 480, 0);
      keys[12 +: 4] = 4'b1000;
      for (int f = 0; f < 3; f++) begin
         run_frame(-1, 0, 0);
         check($sformatf("t4_right_x_f%0d", f), dut_x(3), 485);
      end

      // Overrun tick and load attempts while busy or alongside the tick.
      check("overrun_before", tick_overrun, 0);
      run_frame(2, 1, 0);
      check("overrun_set", tick_overrun, 1);
      run_frame(-1, 0, 1);
      check("overrun_sticky", tick_overrun, 1);

      // Reset in the middle of an update discards the frame.
      frame_tick = 1'b1;
      wait_cyc();
      frame_tick = 1'b0;
      wait_cyc();
      RESET_N = 1'b0;
      #1;
      check("midreset_pos_x", pos_x, 0);
      check("midreset_pos_y", pos_y, 0);
      check("midreset_busy", busy, 0);
      check("midreset_overrun", tick_overrun, 0);
      model_reset();
      wait_cyc();
      RESET_N = 1'b1;
      wait_cyc();
      run_frame(-1, 0, 0);

      // Randomized frames with varying sizes, modes, keys and loads.
      for (int f = 0; f < 40; f++) begin
         for (int i = 0; i < NS; i++) begin
            mode[i] = 1'($urandom_range(0, 1));
            keys[4*i +: 4] = 4'($urandom_range(0, 15));
            set_size(i, ($urandom_range(0, 7) == 0) ? $urandom_range(600, 1023) : $urandom_range(0, 200),
                        ($urandom_range(0, 7) == 0) ? $urandom_range(450, 1023) : $urandom_range(0, 200));
         end
         if ($urandom_range(0, 2) == 0)
            do_load($urandom_range(0, NS - 1), $urandom_range(0, 1023), $urandom_range(0, 1023));
         run_frame(-1, 0, 0);
      end

      repeat (3) wait_cyc();
      check("frame_done_count", done_seen, frames_exp);
      check("scoreboard_drained", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
